// File: rtl/cnt_pkg.sv
// cnt_pkg: shared counter mode constants and parameter legality check
package cnt_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    function automatic bit cnt_params_ok(
        input int     width,
        input longint max_val,
        input longint reset_val
    );
        longint lim;
        lim = (longint'(1) << width) - 1;
        return (width >= 2) && (width <= 32) &&
               (max_val >= 0) && (max_val <= lim) &&
               (reset_val >= 0) && (reset_val <= max_val);
    endfunction

endpackage

// File: rtl/cnt_next_val.sv
// cnt_next_val: combinational one-step count with wrap/saturate and limit event
module cnt_next_val
    import cnt_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MAX_VAL  = (longint'(1) << WIDTH) - 1,
    parameter int     SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_q,
    output logic             event_hit
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam bit               SAT   = (SATURATE == CNT_MODE_SAT);

    logic at_max;
    logic at_min;

    // step one count in the sampled direction; at a limit either wrap or hold
    always_comb begin
        at_max    = (q == MAX_Q);
        at_min    = (q == '0);
        event_hit = up_dn ? at_max : at_min;
        next_q    = up_dn ? (at_max ? (SAT ? q : '0)    : q + 1'b1)
                          : (at_min ? (SAT ? q : MAX_Q) : q - 1'b1);
    end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo up/down counter with clear, load, cascade tc and overflow flags
module mod_updown_counter
    import cnt_pkg::*;
#(
    parameter int     WIDTH     = 4,
    parameter longint MAX_VAL   = (longint'(1) << WIDTH) - 1,
    parameter longint RESET_VAL = 0,
    parameter int     SATURATE  = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sync_clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             evt,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    if (!cnt_params_ok(WIDTH, MAX_VAL, RESET_VAL)) begin : g_param_err
        $error("mod_updown_counter: illegal WIDTH/MAX_VAL/RESET_VAL combination");
    end

    logic [WIDTH-1:0] step_q;
    logic             step_evt;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] nxt_q;
    logic             fire;

    cnt_next_val #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .q         (q),
        .up_dn     (up_dn),
        .next_q    (step_q),
        .event_hit (step_evt)
    );

    // priority clear > load > count > hold; an event only counts when the count step is taken
    always_comb begin
        load_q = (load_val > MAX_Q) ? MAX_Q : load_val;
        nxt_q  = sync_clr ? '0 : load ? load_q : en ? step_q : q;
        fire   = ~sync_clr & ~load & en & step_evt;
        tc     = en & step_evt;
    end

    // count register plus one-cycle event pulse and sticky overflow where set beats clear
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q          <= RESET_Q;
            evt        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            q          <= nxt_q;
            evt        <= fire;
            ovf_sticky <= fire | (ovf_sticky & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: four counter configurations against an arithmetic reference model
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       sync_clr = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       ovf_clr = 1'b0;

    logic [3:0] dq   [4];
    logic       dtc  [4];
    logic       devt [4];
    logic       dovf [4];

    int maxv [4] = '{9, 9, 9, 0};
    int rstv [4] = '{0, 0, 3, 0};
    bit satv [4] = '{0, 1, 0, 0};

    int mq [4];
    bit me [4];
    bit mo [4];

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(0)) u_wrap (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[0]), .tc(dtc[0]), .evt(devt[0]), .ovf_sticky(dovf[0]));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1)) u_sat (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[1]), .tc(dtc[1]), .evt(devt[1]), .ovf_sticky(dovf[1]));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3), .SATURATE(0)) u_rst3 (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[2]), .tc(dtc[2]), .evt(devt[2]), .ovf_sticky(dovf[2]));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(0), .RESET_VAL(0), .SATURATE(0)) u_max0 (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[3]), .tc(dtc[3]), .evt(devt[3]), .ovf_sticky(dovf[3]));

    // unbounded target of one step; leaving 0..max is exactly a limit event
    function automatic int target(int k);
        return mq[k] + (up_dn ? 1 : -1);
    endfunction

    function automatic bit model_evt(int k);
        int t = target(k);
        return !sync_clr && !load && en && (t < 0 || t > maxv[k]);
    endfunction

    function automatic int model_q(int k);
        int t  = target(k);
        int m1 = maxv[k] + 1;
        int lv = int'(load_val);
        if (sync_clr) return 0;
        if (load) return (lv > maxv[k]) ? maxv[k] : lv;
        if (!en) return mq[k];
        if (t >= 0 && t <= maxv[k]) return t;
        if (satv[k]) return (t < 0) ? 0 : maxv[k];
        return (t + m1) % m1;
    endfunction

    function automatic bit model_tc(int k);
        return en && ((up_dn && mq[k] == maxv[k]) || (!up_dn && mq[k] == 0));
    endfunction

    task automatic check(string nm, int k, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0d, want %0d", nm, k, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!clr_n) begin
                mq[k] <= rstv[k];
                me[k] <= 1'b0;
                mo[k] <= 1'b0;
            end else begin
                mq[k] <= model_q(k);
                me[k] <= model_evt(k);
                mo[k] <= model_evt(k) | (mo[k] & !ovf_clr);
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 4; k++) begin
                check("q", k, dq[k], mq[k]);
                check("evt", k, devt[k], me[k]);
                check("ovf_sticky", k, dovf[k], mo[k]);
                check("tc", k, dtc[k], model_tc(k));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        run = 1'b1;
        repeat (2) tick();
        check("lit_reset_q", 0, dq[0], 0);
        check("lit_reset_q", 2, dq[2], 3);
        check("lit_reset_ovf", 3, dovf[3], 0);

        clr_n = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 9)  begin check("lit_up9_q", 0, dq[0], 9); check("lit_up9_tc", 0, dtc[0], 1); end
            if (i == 10) begin check("lit_wrap_q", 0, dq[0], 0); check("lit_wrap_evt", 0, devt[0], 1); check("lit_wrap_ovf", 0, dovf[0], 1); end
            if (i == 11) begin check("lit_evt_drop", 0, devt[0], 0); check("lit_ovf_keep", 0, dovf[0], 1); end
            if (i == 12) begin
                check("lit_sat_q", 1, dq[1], 9); check("lit_sat_evt", 1, devt[1], 1);
                check("lit_rst3_q", 2, dq[2], 5); check("lit_max0_evt", 3, devt[3], 1);
            end
        end

        sync_clr = 1'b1; tick(); sync_clr = 1'b0;
        check("lit_clr_q", 0, dq[0], 0);
        check("lit_clr_evt", 1, devt[1], 0);

        up_dn = 1'b0; #1;
        check("lit_tc_down0", 0, dtc[0], 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 1) check("lit_down_evt", 0, devt[0], 1);
        end
        check("lit_down_q", 0, dq[0], 7);
        check("lit_down_evt_gone", 0, devt[0], 0);
        check("lit_sat_down_q", 1, dq[1], 0);
        check("lit_sat_down_evt", 1, devt[1], 1);

        load = 1'b1; load_val = 4'd14; tick();
        check("lit_load_clamp", 0, dq[0], 9);
        check("lit_load_noevt", 1, devt[1], 0);
        check("lit_load_max0", 3, dq[3], 0);
        sync_clr = 1'b1; tick(); sync_clr = 1'b0;
        check("lit_clr_over_load", 0, dq[0], 0);
        tick(); load = 1'b0;
        check("lit_reload", 0, dq[0], 9);

        en = 1'b0; ovf_clr = 1'b1; tick();
        check("lit_ovf_clr", 0, dovf[0], 0);
        en = 1'b1; up_dn = 1'b1; tick();
        check("lit_ovf_set_wins", 0, dovf[0], 1);
        check("lit_wrap2_q", 0, dq[0], 0);
        en = 1'b0; tick(); ovf_clr = 1'b0;
        check("lit_ovf_clr2", 0, dovf[0], 0);

        sync_clr = 1'b1; tick(); sync_clr = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (5) tick();
        check("lit_pre_abort_q", 2, dq[2], 5);
        check("lit_pre_abort_evt", 3, devt[3], 1);
        #2 clr_n = 1'b0;
        #1;
        check("lit_async_q", 2, dq[2], 3);
        check("lit_async_evt", 3, devt[3], 0);
        check("lit_async_ovf", 3, dovf[3], 0);
        check("lit_async_q", 0, dq[0], 0);
        tick();
        clr_n = 1'b1;
        tick();
        check("lit_resume_q", 2, dq[2], 4);
        tick();
        check("lit_resume_q", 2, dq[2], 5);

        for (int i = 0; i < 60; i++) begin
            sync_clr = ($urandom % 16) == 0;
            load     = ($urandom % 8) == 0;
            en       = ($urandom % 4) != 0;
            up_dn    = $urandom % 2;
            ovf_clr  = ($urandom % 8) == 0;
            load_val = 4'($urandom);
            tick();
        end
        tick();
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the team's free-running 4-bit up counter. Generalised width and modulus, with up/down direction, synchronous clear, parallel load, and enable. Selectable wrap or saturate at the terminal count, plus terminal-count, event-pulse and sticky-overflow outputs. Used as a cascadable sequence/bit counter beside the PRBS LFSR (pattern-length and frame counting).

Parameters:
WIDTH, 4, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, highest count value; sequence is 0..MAX_VAL (modulus MAX_VAL+1); must be ≤ 2**WIDTH-1
RESET_VAL, 0, value of q on clr_n assertion; must be ≤ MAX_VAL
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous clear to 0
en  in  1  count enable
up_dn  in  1  1 = count up, 0 = count down
load  in  1  synchronous parallel load
load_val  in  WIDTH  value for load
ovf_clr  in  1  clears ovf_sticky
q  out  WIDTH  current count (registered)
tc  out  1  combinational terminal count: en & ((up_dn & q==MAX_VAL) | (~up_dn & q==0))
evt  out  1  registered 1-cycle pulse, the cycle after a wrap/saturate event
ovf_sticky  out  1  registered sticky flag, set on any wrap/saturate event

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on clr_n: while low, q=RESET_VAL, evt=0, ovf_sticky=0, independent of clk. Release takes effect on the next rising edge.
- Per-edge priority, highest first: sync_clr > load > en > hold.
- sync_clr=1: q<=0; evt<=0; ovf_sticky unchanged unless ovf_clr.
- load=1: q<=min(load_val, MAX_VAL); out-of-range values clamp to MAX_VAL. No event is generated.
- en=1, up_dn=1, q<MAX_VAL: q<=q+1.
- en=1, up_dn=1, q==MAX_VAL: event. q<=0 if SATURATE=0; q holds MAX_VAL if SATURATE=1.
- en=1, up_dn=0, q>0: q<=q-1.
- en=1, up_dn=0, q==0: event. q<=MAX_VAL if SATURATE=0; q holds 0 if SATURATE=1.
- en=0 and no clear/load: q holds.
- Latency: q reflects a count one edge after en is sampled.
- evt is high for exactly one cycle after each event edge. Consecutive events (e.g. MAX_VAL=0, or held at the limit in saturate mode) keep evt high continuously.
- tc is combinational from q, en and up_dn, for ripple cascading (tc of stage n drives en of stage n+1). It is zero-latency and has no registered delay.
- ovf_sticky: set on an event edge; cleared on an ovf_clr edge. A simultaneous event and ovf_clr leaves it set (set wins).
- Arithmetic is WIDTH bits with no carry-out port. The internal compare against MAX_VAL is WIDTH-bit unsigned.
- up_dn may change every cycle; the direction sampled at the edge applies.
- clr_n asserted mid-count aborts immediately. A pending evt is dropped.

Decomposition:
- Shared package cnt_pkg: localparams CNT_MODE_WRAP=0 and CNT_MODE_SAT=1, plus a parameter-check function. The function flags at elaboration MAX_VAL > 2**WIDTH-1 and RESET_VAL > MAX_VAL.
- One natural sub-module: cnt_next_val, purely combinational. Takes q, up_dn and the parameters; returns next value and event flag. This lets cascaded/multi-channel counters reuse it.
- Top level holds the registers, priority mux, evt and sticky logic.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0. Release clr_n, en=1, up_dn=1 for 12 cycles -> q: 0..9,0,1. evt high one cycle after the 9->0 edge. ovf_sticky=1 from then on. tc=1 while q==9.
- Same config, up_dn=0 from q=0 for 3 cycles -> q: 9,8,7. evt pulses once. tc=1 only while q==0 with en=1.
- SATURATE=1, MAX_VAL=9. Count up 12 cycles -> q stops at 9 and holds. evt high every cycle from the first saturating edge. Then down: q holds at 0 likewise.
- load=1, load_val=14 (MAX_VAL=9) -> q=9 next edge, no evt. Same edge with sync_clr=1 -> q=0 (clear wins).
- Event edge coinciding with ovf_clr=1 -> ovf_sticky stays 1. Next edge, ovf_clr=1 and no event -> ovf_sticky=0.
- clr_n pulsed low mid-cycle at q=5, RESET_VAL=3 -> q=3 and flags 0 immediately, before the next clk edge. Counting resumes 4,5… after release.
